mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_resp_pkg.sv | 32 +++
 rtl/mem_responder_load_extend.sv | 29 ++
 rtl/mem_responder.sv | 169 ++++++++++++++++
 tb/tb_mem_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the wait-stated memory responder.
// Holds the state enum, the funct3 size codes and the alignment/legality check.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [2:0] SIZE_B  = 3'b000;
  localparam logic [2:0] SIZE_H  = 3'b001;
  localparam logic [2:0] SIZE_W  = 3'b010;
  localparam logic [2:0] SIZE_BU = 3'b100;
  localparam logic [2:0] SIZE_HU = 3'b101;

  localparam int CNT_W = 4;

  // Every fault cause except the address range: bad code, misalignment, unsigned store.
  function automatic logic shape_fault(input logic [2:0] size, input logic [1:0] addr_lo,
                                       input logic we);
    case (size)
      SIZE_B:  shape_fault = 1'b0;
      SIZE_H:  shape_fault = addr_lo[0];
      SIZE_W:  shape_fault = (addr_lo != 2'b00);
      SIZE_BU: shape_fault = we;
      SIZE_HU: shape_fault = we | addr_lo[0];
      default: shape_fault = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_responder_load_extend.sv
// Load-path lane selection: picks the byte/half addressed within a word and
// sign- or zero-extends it according to the funct3 size code.
module load_extend
  import mem_resp_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  size,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    shifted  = word >> {byte_off, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = byte_off[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_B:  data = {{24{byte_sel[7]}}, byte_sel};
      SIZE_BU: data = {24'd0, byte_sel};
      SIZE_H:  data = {{16{half_sel[15]}}, half_sel};
      SIZE_HU: data = {16'd0, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Single-port data memory responder with a fixed number of wait states,
// byte/half/word access, sign/zero extension and access-fault reporting.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int MEMORY_SIZE = 128,
  parameter int WAIT_STATES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        WriteEnable,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic [2:0]  size,
  output logic        RespValid,
  output logic [31:0] ReadData,
  output logic        AccessFault
);

  localparam int               IDX_W      = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;
  localparam logic [31:0]      BYTE_LIMIT = 32'(4 * MEMORY_SIZE);
  localparam logic [CNT_W-1:0] CNT_LOAD   = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             resp_q, resp_d;
  logic             fault_q, fault_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [2:0]       size_q, size_d;
  logic             we_q, we_d;

  logic [31:0]      mem_q [MEMORY_SIZE];

  // In IDLE the access (zero-wait or fault) uses the live inputs; afterwards the captured copy.
  logic             in_idle;
  logic [31:0]      op_addr, op_wdata;
  logic [2:0]       op_size;
  logic             op_we, op_fault;
  logic [IDX_W-1:0] op_idx;
  logic [31:0]      mem_word, load_data, lane_data, merged_word;
  logic [3:0]       byte_en;
  logic             do_access, mem_we;

  assign in_idle  = (state_q == ST_IDLE);
  assign op_addr  = in_idle ? Address     : addr_q;
  assign op_wdata = in_idle ? WriteData   : wdata_q;
  assign op_size  = in_idle ? size        : size_q;
  assign op_we    = in_idle ? WriteEnable : we_q;
  assign op_fault = (op_addr >= BYTE_LIMIT) | shape_fault(op_size, op_addr[1:0], op_we);
  assign op_idx   = op_addr[IDX_W+1:2];
  assign mem_word = mem_q[op_idx];

  load_extend u_load_extend (
    .word     (mem_word),
    .byte_off (op_addr[1:0]),
    .size     (op_size),
    .data     (load_data)
  );

  // Replicate the store data across all lanes so the byte enables alone select placement.
  always_comb begin
    lane_data = op_wdata;
    byte_en   = 4'b1111;
    case (op_size)
      SIZE_B: begin
        lane_data = {4{op_wdata[7:0]}};
        byte_en   = 4'b0001 << op_addr[1:0];
      end
      SIZE_H: begin
        lane_data = {2{op_wdata[15:0]}};
        byte_en   = op_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign merged_word[8*gi +: 8] = byte_en[gi] ? lane_data[8*gi +: 8] : mem_word[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    we_d      = we_q;
    do_access = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ReqValid && ready_q) begin
          addr_d  = Address;
          wdata_d = WriteData;
          size_d  = size;
          we_d    = WriteEnable;
          if (op_fault || WAIT_STATES == 0) begin
            do_access = 1'b1;
            state_d   = ST_RESP;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          do_access = 1'b1;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    mem_we  = do_access & op_we & ~op_fault;
    resp_d  = do_access;
    fault_d = do_access & op_fault;
    rdata_d = do_access ? ((op_fault | op_we) ? 32'd0 : load_data) : rdata_q;
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      resp_q  <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      resp_q  <= resp_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      we_q    <= we_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < MEMORY_SIZE; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[op_idx] <= merged_word;
    end
  end

  assign ReqReady    = ready_q;
  assign RespValid   = resp_q;
  assign AccessFault = fault_q;
  assign ReadData    = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table, randomized traffic against a
// byte-addressed reference model, back-to-back, reset-abort and zero-wait cases.
module tb_mem_responder;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic [1:0]        rv = 2'b00;
  logic              we = 1'b0;
  logic [31:0]       addr = '0, wdata = '0;
  logic [2:0]        sz = '0;
  logic [1:0]        ready, rvalid, afault;
  logic [1:0][31:0]  rdata;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mbytes [2][512];

  always #5 CLK = ~CLK;

  // Instance 0: default two wait states; instance 1: zero wait states.
  mem_responder #(.MEMORY_SIZE(128), .WAIT_STATES(2)) dut (
    .CLK(CLK), .RESET(RESET), .ReqValid(rv[0]), .ReqReady(ready[0]),
    .WriteEnable(we), .Address(addr), .WriteData(wdata), .size(sz),
    .RespValid(rvalid[0]), .ReadData(rdata[0]), .AccessFault(afault[0]));

  mem_responder #(.MEMORY_SIZE(128), .WAIT_STATES(0)) dut0 (
    .CLK(CLK), .RESET(RESET), .ReqValid(rv[1]), .ReqReady(ready[1]),
    .WriteEnable(we), .Address(addr), .WriteData(wdata), .size(sz),
    .RespValid(rvalid[1]), .ReadData(rdata[1]), .AccessFault(afault[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 512; i++) mbytes[d][i] = 8'h00;
  endtask

  // Reference: memory as 512 bytes, little-endian, access of n bytes.
  task automatic model(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] s, output logic [31:0] rd, output logic f);
    int n = 4;
    logic uns = 1'b0;
    logic [31:0] v;
    f = 1'b0;
    case (s)
      3'd0: n = 1;
      3'd1: n = 2;
      3'd2: n = 4;
      3'd4: begin n = 1; uns = 1'b1; end
      3'd5: begin n = 2; uns = 1'b1; end
      default: f = 1'b1;
    endcase
    if (!f) f = (a >= 32'd512) || ((a % n) != 0) || (w && uns);
    rd = 32'd0;
    if (!f) begin
      if (w) begin
        for (int k = 0; k < n; k++) mbytes[d][a + k] = wd[8*k +: 8];
      end else begin
        v = 32'd0;
        for (int k = 0; k < n; k++) v = v | (32'(mbytes[d][a + k]) << (8 * k));
        if (!uns && n < 4 && v[8*n-1]) v = v - (32'd1 << (8 * n));
        rd = v;
      end
    end
  endtask

  task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [2:0] s, output logic [31:0] rd, output logic f, output int lat);
    int guard = 0;
    rd = 32'd0; f = 1'b0; lat = -1;
    @(negedge CLK);
    while (!ready[d] && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    if (!ready[d]) begin
      chk("ready_timeout", {31'd0, ready[d]}, 32'd1);
      return;
    end
    we = w; addr = a; wdata = wd; sz = s; rv[d] = 1'b1;
    @(posedge CLK);
    #1;
    rv[d] = 1'b0;
    we = 1'($urandom_range(0, 1)); addr = $urandom; wdata = $urandom; sz = 3'($urandom_range(0, 7));
    lat = 0;
    while (lat < 40) begin
      @(negedge CLK);
      lat++;
      chk("ready_busy", {31'd0, ready[d]}, 32'd0);
      if (rvalid[d]) break;
      chk("fault_no_valid", {31'd0, afault[d]}, 32'd0);
    end
    if (!rvalid[d]) begin
      chk("resp_timeout", {31'd0, rvalid[d]}, 32'd1);
      return;
    end
    rd = rdata[d];
    f  = afault[d];
    @(negedge CLK);
    chk("one_shot", {31'd0, rvalid[d]}, 32'd0);
    chk("fault_idle", {31'd0, afault[d]}, 32'd0);
    chk("rdata_hold", rdata[d], rd);
    chk("ready_back", {31'd0, ready[d]}, 32'd1);
    $display("txn d=%0d we=%0d addr=%h wdata=%h size=%0d -> rdata=%h fault=%0d lat=%0d",
             d, w, a, wd, s, rd, f, lat);
  endtask

  task automatic check_txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                           input logic [2:0] s);
    logic [31:0] rd, exp_rd;
    logic f, exp_f;
    int lat;
    model(d, w, a, wd, s, exp_rd, exp_f);
    txn(d, w, a, wd, s, rd, f, lat);
    chk("rdata", rd, exp_rd);
    chk("fault", {31'd0, f}, {31'd0, exp_f});
    chk("latency", 32'(lat), (exp_f || d == 1) ? 32'd1 : 32'd3);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", {31'd0, ready[d]}, 32'd0);
      chk("rst_valid", {31'd0, rvalid[d]}, 32'd0);
      chk("rst_fault", {31'd0, afault[d]}, 32'd0);
      chk("rst_rdata", rdata[d], 32'd0);
    end
    RESET = 1'b0;
    clear_model();
    @(negedge CLK);
    chk("ready_after_rst", {30'd0, ready}, 32'd3);
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [2:0]  s;
    logic [31:0] exp_rd;
    logic        exp_f;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [31:0] rd;
    logic f;
    int lat, acc, resp;

    tbl.push_back('{1'b1, 32'h10,  32'hDEADBEEF, 3'b010, 32'h00000000, 1'b0});
    tbl.push_back('{1'b0, 32'h10,  32'h0,        3'b010, 32'hDEADBEEF, 1'b0});
    tbl.push_back('{1'b1, 32'h21,  32'hAAAAAA80, 3'b000, 32'h00000000, 1'b0});
    tbl.push_back('{1'b0, 32'h21,  32'h0,        3'b000, 32'hFFFFFF80, 1'b0});
    tbl.push_back('{1'b0, 32'h21,  32'h0,        3'b100, 32'h00000080, 1'b0});
    tbl.push_back('{1'b0, 32'h20,  32'h0,        3'b010, 32'h00008000, 1'b0});
    tbl.push_back('{1'b0, 32'h02,  32'h0,        3'b010, 32'h00000000, 1'b1});
    tbl.push_back('{1'b0, 32'h201, 32'h0,        3'b001, 32'h00000000, 1'b1});
    tbl.push_back('{1'b1, 32'h40,  32'h1234,     3'b101, 32'h00000000, 1'b1});
    tbl.push_back('{1'b0, 32'h0,   32'h0,        3'b011, 32'h00000000, 1'b1});
    tbl.push_back('{1'b1, 32'h1FE, 32'h5555BEEF, 3'b001, 32'h00000000, 1'b0});
    tbl.push_back('{1'b0, 32'h1FE, 32'h0,        3'b001, 32'hFFFFBEEF, 1'b0});
    tbl.push_back('{1'b0, 32'h1FE, 32'h0,        3'b101, 32'h0000BEEF, 1'b0});
    tbl.push_back('{1'b0, 32'h1FC, 32'h0,        3'b010, 32'hBEEF0000, 1'b0});
    tbl.push_back('{1'b0, 32'h200, 32'h0,        3'b010, 32'h00000000, 1'b1});

    do_reset();

    foreach (tbl[i]) begin
      txn(0, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].s, rd, f, lat);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_fault", i), {31'd0, f}, {31'd0, tbl[i].exp_f});
      chk($sformatf("tbl%0d_lat", i), 32'(lat), tbl[i].exp_f ? 32'd1 : 32'd3);
    end

    // Zero-wait instance: halfword store then word readback.
    txn(1, 1'b1, 32'h42, 32'h00001234, 3'b001, rd, f, lat);
    chk("ws0_store_lat", 32'(lat), 32'd1);
    chk("ws0_store_fault", {31'd0, f}, 32'd0);
    txn(1, 1'b0, 32'h40, 32'h0, 3'b010, rd, f, lat);
    chk("ws0_load_lat", 32'(lat), 32'd1);
    chk("ws0_load_data", rd, 32'h12340000);

    // Randomized traffic against the reference model on both instances.
    do_reset();
    for (int i = 0; i < 160; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 32'h21F));
      check_txn(i % 4 == 3 ? 1 : 0, 1'($urandom_range(0, 1)), a, $urandom,
                3'($urandom_range(0, 7)));
    end

    // ReqValid held high: one acceptance per WAIT_STATES+2 cycles.
    @(negedge CLK);
    while (!ready[0]) @(negedge CLK);
    we = 1'b0; addr = 32'h10; sz = 3'b010; rv[0] = 1'b1;
    acc = 0; resp = 0;
    for (int c = 0; c < 16; c++) begin
      if (ready[0]) acc++;
      if (rvalid[0]) resp++;
      @(negedge CLK);
    end
    rv[0] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (rvalid[0]) resp++;
      @(negedge CLK);
    end
    chk("hold_accepts", 32'(acc), 32'd4);
    chk("hold_responses", 32'(resp), 32'd4);

    // Reset pulsed while a store waits: no response, memory stays clear.
    we = 1'b1; addr = 32'h30; wdata = 32'hCAFEF00D; sz = 3'b010; rv[0] = 1'b1;
    @(posedge CLK);
    #1;
    rv[0] = 1'b0;
    @(negedge CLK);
    chk("abort_in_wait", {31'd0, ready[0]}, 32'd0);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    clear_model();
    resp = 0;
    for (int c = 0; c < 6; c++) begin
      if (rvalid[0]) resp++;
      @(negedge CLK);
    end
    chk("abort_no_resp", 32'(resp), 32'd0);
    txn(0, 1'b0, 32'h30, 32'h0, 3'b010, rd, f, lat);
    chk("abort_readback", rd, 32'h00000000);
    chk("abort_readback_fault", {31'd0, f}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
